// File: rtl/ip_ram_arbiter_if.sv
`timescale 1ns/1ps
// Bus bundle between the IP RAM arbiter, its CPU/video requesters and the byte-wide RAM port.
interface ip_ram_arbiter_if #(
  parameter int ADDR_W = 19
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_done;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [7:0]        vid_rdata;
  logic              vid_done;
  logic [ADDR_W-1:0] ram_address;
  logic [7:0]        ram_writedata;
  logic              ram_write_enable;
  logic [7:0]        ram_readdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, ram_readdata,
    output cpu_rdata, cpu_done, vid_rdata, vid_done,
    output ram_address, ram_writedata, ram_write_enable
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, ram_readdata,
    input  cpu_rdata, cpu_done, vid_rdata, vid_done,
    input  ram_address, ram_writedata, ram_write_enable
  );
endinterface

// File: rtl/ip_ram_arbiter.sv
`timescale 1ns/1ps
// Round-robin owner of the byte-wide IP RAM port: CPU word accesses are serialised into
// four little-endian byte accesses, video byte reads are passed through one at a time.
module ip_ram_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  ip_ram_arbiter_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_CPU_WR, S_CPU_RD, S_VID_RD, S_DRAIN, S_DONE} state_t;
  typedef enum logic {OWN_CPU, OWN_VID} owner_t;

  localparam int         RL         = READ_LATENCY;
  localparam logic [1:0] DRAIN_LAST = 2'(RL - 1);

  state_t             state_q, state_d;
  owner_t             last_grant_q, last_grant_d;
  logic [1:0]         cnt_q, cnt_d, cnt_nxt;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [RL-1:0]      pvld_q, pvld_d;
  logic [RL-1:0][1:0] pidx_q, pidx_d;
  logic [23:0]        rbuf_q, rbuf_d;
  logic               push;
  logic               grant_cpu, grant_vid;
  logic [ADDR_W-1:0]  ram_address_q, ram_address_d;
  logic [7:0]         ram_writedata_q, ram_writedata_d;
  logic               ram_we_q, ram_we_d;
  logic               cpu_done_q, cpu_done_d;
  logic               vid_done_q, vid_done_d;
  logic [31:0]        cpu_rdata_q, cpu_rdata_d;
  logic [7:0]         vid_rdata_q, vid_rdata_d;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    cnt_d           = cnt_q;
    cnt_nxt         = cnt_q + 2'd1;
    base_d          = base_q;
    wdata_d         = wdata_q;
    ram_address_d   = ram_address_q;
    ram_writedata_d = ram_writedata_q;
    ram_we_d        = 1'b0;
    cpu_done_d      = 1'b0;
    vid_done_d      = 1'b0;
    cpu_rdata_d     = cpu_rdata_q;
    vid_rdata_d     = vid_rdata_q;
    push            = 1'b0;
    grant_cpu       = 1'b0;
    grant_vid       = 1'b0;

    // Outputs are registered, so each branch computes what the RAM port shows next cycle.
    case (state_q)
      S_IDLE: begin
        grant_cpu = bus.cpu_req && (!bus.vid_req || last_grant_q == OWN_VID);
        grant_vid = bus.vid_req && !grant_cpu;
        if (grant_cpu) begin
          last_grant_d  = OWN_CPU;
          base_d        = bus.cpu_addr;
          wdata_d       = bus.cpu_wdata;
          cnt_d         = 2'd0;
          ram_address_d = bus.cpu_addr;
          if (bus.cpu_we) begin
            state_d         = S_CPU_WR;
            ram_we_d        = 1'b1;
            ram_writedata_d = bus.cpu_wdata[7:0];
          end else begin
            state_d = S_CPU_RD;
          end
        end else if (grant_vid) begin
          last_grant_d  = OWN_VID;
          cnt_d         = 2'd0;
          ram_address_d = bus.vid_addr;
          state_d       = S_VID_RD;
        end
      end
      S_CPU_WR: begin
        if (cnt_q == 2'd3) begin
          state_d    = S_DONE;
          cpu_done_d = 1'b1;
        end else begin
          cnt_d           = cnt_nxt;
          ram_address_d   = base_q + ADDR_W'(cnt_nxt);
          ram_writedata_d = byte_of(wdata_q, cnt_nxt);
          ram_we_d        = 1'b1;
        end
      end
      S_CPU_RD: begin
        push = 1'b1;
        if (cnt_q == 2'd3) begin
          state_d = S_DRAIN;
          cnt_d   = 2'd0;
        end else begin
          cnt_d         = cnt_nxt;
          ram_address_d = base_q + ADDR_W'(cnt_nxt);
        end
      end
      S_VID_RD: begin
        push    = 1'b1;
        state_d = S_DRAIN;
        cnt_d   = 2'd0;
      end
      S_DRAIN: begin
        // The last byte arrives in the final drain cycle and goes straight to the output.
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
          if (last_grant_q == OWN_CPU) begin
            cpu_rdata_d = {bus.ram_readdata, rbuf_q};
            cpu_done_d  = 1'b1;
          end else begin
            vid_rdata_d = bus.ram_readdata;
            vid_done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_nxt;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read-return tracker: tags each presented address with its byte lane, RL cycles deep.
  always_comb begin
    pvld_d    = '0;
    pidx_d    = '0;
    pvld_d[0] = push;
    pidx_d[0] = cnt_q;
    for (int i = 1; i < RL; i++) begin
      pvld_d[i] = pvld_q[i-1];
      pidx_d[i] = pidx_q[i-1];
    end
    rbuf_d = rbuf_q;
    if (pvld_q[RL-1]) begin
      case (pidx_q[RL-1])
        2'd0:    rbuf_d[7:0]   = bus.ram_readdata;
        2'd1:    rbuf_d[15:8]  = bus.ram_readdata;
        2'd2:    rbuf_d[23:16] = bus.ram_readdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      last_grant_q    <= OWN_VID;
      cnt_q           <= 2'd0;
      pvld_q          <= '0;
      ram_address_q   <= '0;
      ram_writedata_q <= '0;
      ram_we_q        <= 1'b0;
      cpu_done_q      <= 1'b0;
      vid_done_q      <= 1'b0;
      cpu_rdata_q     <= '0;
      vid_rdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      cnt_q           <= cnt_d;
      pvld_q          <= pvld_d;
      ram_address_q   <= ram_address_d;
      ram_writedata_q <= ram_writedata_d;
      ram_we_q        <= ram_we_d;
      cpu_done_q      <= cpu_done_d;
      vid_done_q      <= vid_done_d;
      cpu_rdata_q     <= cpu_rdata_d;
      vid_rdata_q     <= vid_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    base_q  <= base_d;
    wdata_q <= wdata_d;
    pidx_q  <= pidx_d;
    rbuf_q  <= rbuf_d;
  end

  assign bus.ram_address      = ram_address_q;
  assign bus.ram_writedata    = ram_writedata_q;
  assign bus.ram_write_enable = ram_we_q;
  assign bus.cpu_done         = cpu_done_q;
  assign bus.vid_done         = vid_done_q;
  assign bus.cpu_rdata        = cpu_rdata_q;
  assign bus.vid_rdata        = vid_rdata_q;
endmodule

// File: tb/tb_ip_ram_arbiter.sv
`timescale 1ns/1ps
// Bench for ip_ram_arbiter: a READ_LATENCY=1 instance checked through a scoreboard and a
// READ_LATENCY=2 instance checked directly, each backed by a behavioural byte RAM.
module tb_ip_ram_arbiter;
  localparam int AW = 19;
  localparam logic [1:0] K_WR = 2'd0, K_CPU = 2'd1, K_VID = 2'd2;
  localparam logic [1:0] OP_WR = 2'd0, OP_RD = 2'd1, OP_VID = 2'd2;

  typedef struct {
    logic [1:0]    kind;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } sb_t;

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp_data;
    int            exp_lat;
  } vec_t;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;
  sb_t  sbq[$];

  ip_ram_arbiter_if #(.ADDR_W(AW)) b1 ();
  ip_ram_arbiter_if #(.ADDR_W(AW)) b2 ();

  ip_ram_arbiter #(.ADDR_W(AW), .READ_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  ip_ram_arbiter #(.ADDR_W(AW), .READ_LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem1 [0:(1<<AW)-1];
  logic [7:0] mem2 [0:(1<<AW)-1];
  logic [7:0] rd1, rd2a, rd2b;

  always @(posedge clk) begin
    rd1 <= mem1[b1.ram_address];
    if (b1.ram_write_enable) mem1[b1.ram_address] <= b1.ram_writedata;
  end
  always @(posedge clk) begin
    rd2a <= mem2[b2.ram_address];
    rd2b <= rd2a;
    if (b2.ram_write_enable) mem2[b2.ram_address] <= b2.ram_writedata;
  end
  assign b1.ram_readdata = rd1;
  assign b2.ram_readdata = rd2b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    nvec++;
    if (act !== exp_v) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic sb_take(input logic [1:0] kind, input logic [AW-1:0] a, input logic [31:0] d);
    sb_t e;
    if (sbq.size() == 0 || sbq[0].kind != kind) begin
      nvec++;
      nerr++;
      $display("FAIL sb_unexpected: event kind %0d addr %h data %h at %0t", kind, a, d, $time);
    end else begin
      e = sbq.pop_front();
      if (kind == K_WR) chk("sb_ram_write", {5'b0, a, d[7:0]}, {5'b0, e.addr, e.data[7:0]});
      else if (kind == K_CPU) chk("sb_cpu_rdata", d, e.data);
      else chk("sb_vid_rdata", d, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (b1.ram_write_enable) sb_take(K_WR, b1.ram_address, {24'h0, b1.ram_writedata});
      if (b1.cpu_done) sb_take(K_CPU, '0, b1.cpu_rdata);
      if (b1.vid_done) sb_take(K_VID, '0, {24'h0, b1.vid_rdata});
      if (b1.cpu_done && b1.vid_done) chk("done_exclusive", 32'd1, 32'd0);
    end
  end

  task automatic push_exp(input vec_t v);
    if (v.op == OP_WR) begin
      for (int k = 0; k < 4; k++)
        sbq.push_back('{K_WR, AW'(v.addr + AW'(k)), {24'h0, v.wdata[8*k +: 8]}});
      sbq.push_back('{K_CPU, '0, v.exp_data});
    end else if (v.op == OP_RD) begin
      sbq.push_back('{K_CPU, '0, v.exp_data});
    end else begin
      sbq.push_back('{K_VID, '0, v.exp_data});
    end
  endtask

  // Starts in an IDLE cycle, returns in the IDLE cycle after DONE.
  task automatic run_txn(input bit on2, input vec_t v);
    bit hit;
    int n;
    hit = 1'b0;
    n   = 0;
    if (v.op == OP_VID) begin
      if (on2) begin b2.vid_addr = v.addr; b2.vid_req = 1'b1; end
      else begin b1.vid_addr = v.addr; b1.vid_req = 1'b1; end
    end else begin
      if (on2) begin
        b2.cpu_we = (v.op == OP_WR); b2.cpu_addr = v.addr; b2.cpu_wdata = v.wdata; b2.cpu_req = 1'b1;
      end else begin
        b1.cpu_we = (v.op == OP_WR); b1.cpu_addr = v.addr; b1.cpu_wdata = v.wdata; b1.cpu_req = 1'b1;
      end
    end
    while (!hit && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        b1.cpu_addr = AW'($urandom); b1.vid_addr = AW'($urandom); b1.cpu_wdata = $urandom;
        b2.cpu_addr = AW'($urandom); b2.vid_addr = AW'($urandom); b2.cpu_wdata = $urandom;
      end
      if (v.op == OP_VID) hit = on2 ? b2.vid_done : b1.vid_done;
      else hit = on2 ? b2.cpu_done : b1.cpu_done;
    end
    b1.cpu_req = 1'b0; b1.vid_req = 1'b0;
    b2.cpu_req = 1'b0; b2.vid_req = 1'b0;
    chk("done_latency", n, v.exp_lat);
    if (on2 && hit) begin
      if (v.op == OP_VID) chk("l2_vid_rdata", {24'h0, b2.vid_rdata}, v.exp_data);
      else chk("l2_cpu_rdata", b2.cpu_rdata, v.exp_data);
    end
    @(posedge clk); #1;
  endtask

  // Both requesters hammer the port, each dropping at its done and re-raising one cycle later.
  task automatic race(input int n, input bit vid_first);
    int  got, cyc;
    bit  rc, rv, is_vid;
    for (int i = 0; i < n; i++) begin
      is_vid = ((i % 2) == 1) ^ vid_first;
      if (is_vid) sbq.push_back('{K_VID, '0, 32'h0000_0044});
      else sbq.push_back('{K_CPU, '0, 32'hF00D_BEEF});
    end
    b1.cpu_we = 1'b0; b1.cpu_addr = 19'h00100; b1.vid_addr = 19'h7FFFE;
    b1.cpu_req = 1'b1; b1.vid_req = 1'b1;
    got = 0; cyc = 0; rc = 1'b0; rv = 1'b0;
    while (got < n && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (rc) begin b1.cpu_req = 1'b1; rc = 1'b0; end
      if (rv) begin b1.vid_req = 1'b1; rv = 1'b0; end
      if (b1.cpu_done) begin b1.cpu_req = 1'b0; rc = 1'b1; got++; end
      if (b1.vid_done) begin b1.vid_req = 1'b0; rv = 1'b1; got++; end
    end
    b1.cpu_req = 1'b0; b1.vid_req = 1'b0;
    chk("race_done_count", got, n);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl [9];
  vec_t v;

  initial begin
    nvec = 0;
    nerr = 0;
    tbl[0] = '{OP_WR,  19'h00100, 32'hDEAD_BEEF, 32'h0000_0000, 5};
    tbl[1] = '{OP_RD,  19'h00100, 32'h0,         32'hDEAD_BEEF, 6};
    tbl[2] = '{OP_WR,  19'h7FFFE, 32'h1122_3344, 32'hDEAD_BEEF, 5};
    tbl[3] = '{OP_RD,  19'h7FFFE, 32'h0,         32'h1122_3344, 6};
    tbl[4] = '{OP_WR,  19'h00102, 32'hCAFE_F00D, 32'h1122_3344, 5};
    tbl[5] = '{OP_RD,  19'h00101, 32'h0,         32'hFEF0_0DBE, 6};
    tbl[6] = '{OP_VID, 19'h00105, 32'h0,         32'h0000_00CA, 3};
    tbl[7] = '{OP_VID, 19'h7FFFF, 32'h0,         32'h0000_0033, 3};
    tbl[8] = '{OP_VID, 19'h00000, 32'h0,         32'h0000_0022, 3};

    rst = 1'b1;
    b1.cpu_req = 1'b0; b1.cpu_we = 1'b0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.vid_req = 1'b0; b1.vid_addr = '0;
    b2.cpu_req = 1'b0; b2.cpu_we = 1'b0; b2.cpu_addr = '0; b2.cpu_wdata = '0;
    b2.vid_req = 1'b0; b2.vid_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ram_address", {13'h0, b1.ram_address}, 32'h0);
    chk("rst_ram_writedata", {24'h0, b1.ram_writedata}, 32'h0);
    chk("rst_ram_we", {31'h0, b1.ram_write_enable}, 32'h0);
    chk("rst_cpu_done", {31'h0, b1.cpu_done}, 32'h0);
    chk("rst_vid_done", {31'h0, b1.vid_done}, 32'h0);
    chk("rst_cpu_rdata", b1.cpu_rdata, 32'h0);
    chk("rst_vid_rdata", {24'h0, b1.vid_rdata}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      push_exp(tbl[i]);
      run_txn(1'b0, tbl[i]);
    end

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    race(4, 1'b0);
    v = '{OP_RD, 19'h00100, 32'h0, 32'hF00D_BEEF, 6};
    push_exp(v);
    run_txn(1'b0, v);
    race(2, 1'b1);

    // Abort a write in its second byte cycle: only byte 0 may land in RAM.
    sbq.push_back('{K_WR, 19'h00100, 32'h0000_00DD});
    b1.cpu_we = 1'b1; b1.cpu_addr = 19'h00100; b1.cpu_wdata = 32'hAABB_CCDD; b1.cpu_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_we_low", {31'h0, b1.ram_write_enable}, 32'h0);
    chk("abort_no_done", {31'h0, b1.cpu_done}, 32'h0);
    b1.cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_cpu_rdata_clr", b1.cpu_rdata, 32'h0);
    @(posedge clk); #1;
    v = '{OP_VID, 19'h00000, 32'h0, 32'h0000_0022, 3};
    push_exp(v);
    run_txn(1'b0, v);
    v = '{OP_RD, 19'h00100, 32'h0, 32'hF00D_BEDD, 6};
    push_exp(v);
    run_txn(1'b0, v);

    v = '{OP_WR, 19'h00400, 32'h1234_565A, 32'h0, 5};
    run_txn(1'b1, v);
    v = '{OP_VID, 19'h00400, 32'h0, 32'h0000_005A, 4};
    run_txn(1'b1, v);
    chk("l2_cpu_rdata_held", b2.cpu_rdata, 32'h0);
    v = '{OP_RD, 19'h00400, 32'h0, 32'h1234_565A, 7};
    run_txn(1'b1, v);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_leftover", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/ip_ram_arbiter.md
Name: ip_ram_arbiter

Overview:
Owns the single byte-wide port of the on-chip IP RAM and shares it between two requesters. The CPU data port issues 32-bit word reads and writes, which the block serialises into four little-endian byte accesses. The video/scan port issues single-byte reads. Arbitration is round-robin. Each transaction uses a level request and a one-cycle done pulse.

Parameters:
ADDR_W, 19, RAM byte-address width.
READ_LATENCY, 1, cycles from address presented to ram_readdata valid; legal values are 1 and 2.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU transaction request (level)
cpu_we  in  1  1 = word write, 0 = word read; sampled at grant
cpu_addr  in  ADDR_W  byte base address; sampled at grant
cpu_wdata  in  32  write word; sampled at grant
cpu_rdata  out  32  assembled read word
cpu_done  out  1  one-cycle completion pulse
vid_req  in  1  video byte-read request (level)
vid_addr  in  ADDR_W  byte address; sampled at grant
vid_rdata  out  8  read byte
vid_done  out  1  one-cycle completion pulse
ram_address  out  ADDR_W  RAM address
ram_writedata  out  8  RAM write byte
ram_write_enable  out  1  RAM write strobe
ram_readdata  in  8  RAM read byte, valid READ_LATENCY cycles after its address

Behaviour:
- All outputs are registered. Reset value of every output is 0.
- Reset also forces the state to IDLE, clears the byte counter, and sets last_grant=VID so the CPU wins the first tie.
- States: IDLE, CPU_WR, CPU_RD, VID_RD, DRAIN, DONE.
- IDLE, arbitration on each edge:
  - Only cpu_req high: grant CPU.
  - Only vid_req high: grant VID.
  - Both high: grant the requester that is not last_grant.
  - Neither high: stay in IDLE.
  - At the grant edge the block latches addr, data and we, and updates last_grant.
- Timing below is relative to G, the cycle in which the grant edge occurs.
- CPU write:
  - Cycles G+1..G+4 present byte k (k=0..3) with ram_address=base+k, ram_writedata=wdata[8k+7:8k], ram_write_enable=1.
  - Cycle G+5 is DONE: cpu_done=1, ram_write_enable=0.
- CPU read:
  - Cycles G+1..G+4 present base+k with ram_write_enable=0.
  - Byte k is captured at the end of cycle G+1+k+READ_LATENCY. DRAIN holds for READ_LATENCY cycles.
  - DONE is cycle G+5+READ_LATENCY. In that cycle cpu_rdata={b3,b2,b1,b0} and cpu_done=1.
  - cpu_rdata is held until the next CPU read completes; a write never alters it.
- VID read:
  - Cycle G+1 presents vid_addr with ram_write_enable=0.
  - The byte is captured at the end of G+1+READ_LATENCY.
  - DONE is cycle G+2+READ_LATENCY, with vid_rdata valid and vid_done=1. vid_rdata is held until the next video read.
- DONE always returns to IDLE, so one dead IDLE cycle separates every pair of transactions.
- Requester rule: a requester deasserts req at the edge where it samples done=1. If req is still high in the following IDLE cycle, it is a new request.
- Request inputs are ignored in every state except IDLE. addr and data may change after the grant edge.
- Address arithmetic is base+k modulo 2^ADDR_W; 0x7FFFF+1 wraps to 0x00000. Unaligned base addresses are legal.
- ram_write_enable is 1 only in CPU_WR. ram_address and ram_writedata hold their last values when idle.
- Reset mid-transaction:
  - Immediate abort: ram_write_enable and both done outputs go to 0 asynchronously.
  - No done pulse is issued. Bytes already written stay in RAM, and the requester reissues.
- The done pulses are mutually exclusive; only one transaction is ever in flight.

Test Plan:
1. Write: CPU write 0xDEADBEEF at 0x00100 -> cycles G+1..G+4 show EF@0x100, BE@0x101, AD@0x102, DE@0x103 with write enable high. cpu_done=1 only in G+5.
2. Read-back, READ_LATENCY=1: CPU read at 0x00100 after test 1 -> cpu_rdata=0xDEADBEEF and cpu_done=1 in G+6. ram_write_enable stays 0 throughout.
3. Round-robin: after reset, hold cpu_req and vid_req high, each dropped per the requester rule then re-raised -> grant order CPU, VID, CPU, VID. No grant while busy.
4. Wrap-around: CPU write 0x11223344 at 0x7FFFE -> 44@0x7FFFE, 33@0x7FFFF, 22@0x00000, 11@0x00001.
5. Reset mid-operation: assert rst during G+2 of a write -> ram_write_enable falls before the next edge, no cpu_done. After release, a VID read of 0x00000 returns 0x22 with vid_done.
6. Video read, READ_LATENCY=2: model byte 0x5A at 0x00400 -> vid_rdata=0x5A and vid_done=1 in G+4. cpu_rdata is unchanged.
